sys_rx_ctrl: RTL and testbench

//  Command sequencer downstream of the UART receiver. Consumes received bytes (P_DATA/DATA_VALID),

---
 rtl/sys_rx_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_sys_rx_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_rx_ctrl.sv
// sys_rx_ctrl: command sequencer behind the UART receiver.
//   Decodes received command frames into register-file writes/reads and ALU
//   runs (with ALU clock gating), and returns read/ALU results as bytes
//   through the transmitter valid/busy handshake.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_p_data/rx_d_vld          received byte + one-cycle strobe
//   rf_wr_en/rf_rd_en           register-file write/read strobes (1 cycle)
//   rf_addr/rf_wr_data          register-file address / write data
//   rf_rd_data/rf_rd_vld        register-file read return
//   alu_en/alu_fun              ALU start strobe / function code
//   alu_out/alu_out_vld         ALU result + valid strobe
//   clk_gate_en                 ALU clock-gate enable
//   tx_p_data/tx_d_vld/tx_busy  transmitter handshake
//
// Frames
//   AA addr data        register write
//   BB addr             register read, 1 byte returned
//   CC opa opb fun      opa->addr 0, opb->addr 1, ALU run, 2 bytes returned
//   DD fun              ALU run on current operands, 2 bytes returned
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for a command byte
// WR_ADDR    | write frame, waiting for address byte
// WR_DATA    | write frame, waiting for data byte
// RD_ADDR    | read frame, waiting for address byte
// RD_WAIT    | read issued, waiting for rf_rd_vld
// OPA        | ALU frame, waiting for operand A (written to addr 0)
// OPB        | ALU frame, waiting for operand B (written to addr 1)
// FUN        | waiting for ALU function byte
// GATE       | ALU clock enabled, ALU start issued on leaving
// ALU_WAIT   | waiting for alu_out_vld
// TX_BYTE0   | sending result[7:0]
// TX_BYTE1   | sending result[15:8] (or read data)

module sys_rx_ctrl #(
  parameter int         ADDR_W     = 4,
  parameter logic [7:0] CMD_WR     = 8'hAA,
  parameter logic [7:0] CMD_RD     = 8'hBB,
  parameter logic [7:0] CMD_ALU_OP = 8'hCC,
  parameter logic [7:0] CMD_ALU_NO = 8'hDD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_p_data,
  input  logic              rx_d_vld,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wr_data,
  input  logic [7:0]        rf_rd_data,
  input  logic              rf_rd_vld,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  input  logic [15:0]       alu_out,
  input  logic              alu_out_vld,
  output logic              clk_gate_en,
  output logic [7:0]        tx_p_data,
  output logic              tx_d_vld,
  input  logic              tx_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OPA, S_OPB,
    S_FUN, S_GATE, S_ALU_WAIT, S_TX_BYTE0, S_TX_BYTE1
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         result_q, result_d;
  logic                rf_wr_en_d, rf_rd_en_d, alu_en_d;
  logic [ADDR_W-1:0]   rf_addr_d;
  logic [7:0]          rf_wr_data_d;
  logic [3:0]          alu_fun_d;
  logic                clk_gate_en_d;
  logic [7:0]          tx_p_data_d;
  logic                tx_d_vld_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= '0;
      rf_wr_data  <= '0;
      alu_en      <= 1'b0;
      alu_fun     <= '0;
      clk_gate_en <= 1'b0;
      tx_p_data   <= '0;
      tx_d_vld    <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      rf_wr_en    <= rf_wr_en_d;
      rf_rd_en    <= rf_rd_en_d;
      rf_addr     <= rf_addr_d;
      rf_wr_data  <= rf_wr_data_d;
      alu_en      <= alu_en_d;
      alu_fun     <= alu_fun_d;
      clk_gate_en <= clk_gate_en_d;
      tx_p_data   <= tx_p_data_d;
      tx_d_vld    <= tx_d_vld_d;
    end
  end

  // Every output is a register; this block computes their next values.
  // Strobes default low, everything else holds.
  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    alu_en_d      = 1'b0;
    rf_addr_d     = rf_addr;
    rf_wr_data_d  = rf_wr_data;
    alu_fun_d     = alu_fun;
    clk_gate_en_d = clk_gate_en;
    tx_p_data_d   = tx_p_data;
    tx_d_vld_d    = tx_d_vld;

    case (state_q)
      S_IDLE: begin
        if (rx_d_vld) begin
          case (rx_p_data)
            CMD_WR:     state_d = S_WR_ADDR;
            CMD_RD:     state_d = S_RD_ADDR;
            CMD_ALU_OP: state_d = S_OPA;
            CMD_ALU_NO: state_d = S_FUN;
            default:    state_d = S_IDLE;
          endcase
        end
      end

      S_WR_ADDR: begin
        if (rx_d_vld) begin
          rf_addr_d = rx_p_data[ADDR_W-1:0];
          state_d   = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (rx_d_vld) begin
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (rx_d_vld) begin
          rf_addr_d  = rx_p_data[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = S_RD_WAIT;
        end
      end

      // Read data goes in the upper result byte so the single-byte reply
      // reuses the TX_BYTE1 path.
      S_RD_WAIT: begin
        if (rf_rd_vld) begin
          result_d[15:8] = rf_rd_data;
          state_d        = S_TX_BYTE1;
        end
      end

      S_OPA: begin
        if (rx_d_vld) begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_OPB;
        end
      end

      S_OPB: begin
        if (rx_d_vld) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_FUN;
        end
      end

      S_FUN: begin
        if (rx_d_vld) begin
          alu_fun_d     = rx_p_data[3:0];
          clk_gate_en_d = 1'b1;
          state_d       = S_GATE;
        end
      end

      // Clock gate has been open for one cycle; start the ALU now.
      S_GATE: begin
        alu_en_d = 1'b1;
        state_d  = S_ALU_WAIT;
      end

      S_ALU_WAIT: begin
        if (alu_out_vld) begin
          result_d      = alu_out;
          clk_gate_en_d = 1'b0;
          state_d       = S_TX_BYTE0;
        end
      end

      S_TX_BYTE0, S_TX_BYTE1: begin
        if (!tx_d_vld) begin
          if (!tx_busy) begin
            tx_p_data_d = (state_q == S_TX_BYTE0) ? result_q[7:0] : result_q[15:8];
            tx_d_vld_d  = 1'b1;
          end
        end else if (tx_busy) begin
          // Transmitter has taken the byte.
          tx_d_vld_d = 1'b0;
          state_d    = (state_q == S_TX_BYTE0) ? S_TX_BYTE1 : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sys_rx_ctrl.sv
// Self-checking bench for sys_rx_ctrl: directed frames followed by random
// frames, compared at transaction level (RF writes, RF reads, ALU runs,
// transmitted bytes) against a frame-level reference model.

module tb_sys_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_vld = 1'b0;
  logic        rf_wr_en, rf_rd_en;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic [7:0]  rf_rd_data = '0;
  logic        rf_rd_vld = 1'b0;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic [15:0] alu_out = '0;
  logic        alu_out_vld = 1'b0;
  logic        clk_gate_en;
  logic [7:0]  tx_p_data;
  logic        tx_d_vld;
  logic        tx_busy;
  logic        tx_busy_r = 1'b0;
  logic        busy_force = 1'b0;

  assign tx_busy = tx_busy_r | busy_force;

  always #5 clk = ~clk;

  sys_rx_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rx_p_data(rx_p_data), .rx_d_vld(rx_d_vld),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_data(rf_rd_data), .rf_rd_vld(rf_rd_vld),
    .alu_en(alu_en), .alu_fun(alu_fun), .alu_out(alu_out), .alu_out_vld(alu_out_vld),
    .clk_gate_en(clk_gate_en),
    .tx_p_data(tx_p_data), .tx_d_vld(tx_d_vld), .tx_busy(tx_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int rst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU used by the ALU responder and by the reference model.
  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f[1:0])
      2'd0:    return 16'(a) + 16'(b);
      2'd1:    return 16'(a) - 16'(b);
      2'd2:    return 16'(a) * 16'(b);
      default: return {a ^ b, a & b} ^ {12'h0, f};
    endcase
  endfunction

  // Register file as seen by the responders, and the reference model's view.
  logic [7:0]  rf_mem [16];
  logic [7:0]  mem_m  [16];

  logic [11:0] obs_wr[$], exp_wr[$];
  logic [3:0]  obs_rd[$], exp_rd[$];
  logic [3:0]  obs_alu[$], exp_alu[$];
  logic [7:0]  obs_tx[$], exp_tx[$];
  logic [7:0]  frame_q[$];

  int          rd_dly = 2;
  int          alu_dly = 4;
  logic        alu_force_en = 1'b0;
  logic [15:0] alu_force_val = '0;

  // Monitor
  logic gate_d = 1'b0;
  logic aov_d = 1'b0;
  always @(negedge clk) begin
    if (rf_wr_en) begin
      obs_wr.push_back({rf_addr, rf_wr_data});
      rf_mem[rf_addr] = rf_wr_data;
    end
    if (rf_rd_en) obs_rd.push_back(rf_addr);
    if (alu_en) begin
      obs_alu.push_back(alu_fun);
      chk("gate_at_alu_en", 32'({gate_d, clk_gate_en}), 32'(2'b11));
    end
    if (aov_d) chk("gate_off_after_vld", 32'(clk_gate_en), 32'(0));
    gate_d = clk_gate_en;
    aov_d  = alu_out_vld;
  end

  // Register-file read responder
  logic [3:0] rd_a;
  always begin
    @(negedge clk);
    if (rst_n && rf_rd_en) begin
      rd_a = rf_addr;
      repeat (rd_dly) @(posedge clk);
      #1;
      rf_rd_data = rf_mem[rd_a];
      rf_rd_vld  = 1'b1;
      @(posedge clk);
      #1 rf_rd_vld = 1'b0;
    end
  end

  // ALU responder; abandons the run if reset occurs meanwhile
  logic [3:0] alu_f;
  int         alu_rc;
  always begin
    @(negedge clk);
    if (rst_n && alu_en) begin
      alu_f  = alu_fun;
      alu_rc = rst_cnt;
      repeat (alu_dly) @(posedge clk);
      #1;
      if (alu_rc == rst_cnt) begin
        chk("alu_fun_hold", 32'(alu_fun), 32'(alu_f));
        alu_out     = alu_force_en ? alu_force_val : alu_ref(alu_f, rf_mem[0], rf_mem[1]);
        alu_out_vld = 1'b1;
        @(posedge clk);
        #1 alu_out_vld = 1'b0;
      end
    end
  end

  // Transmitter responder: accepts after a random delay, stays busy a while
  logic [7:0] tx_cap;
  always begin
    @(negedge clk);
    if (rst_n && tx_d_vld && !tx_busy) begin
      tx_cap = tx_p_data;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("tx_hold", 32'({tx_d_vld, tx_p_data}), 32'({1'b1, tx_cap}));
      end
      @(posedge clk);
      #1;
      chk("tx_hold_accept", 32'({tx_d_vld, tx_p_data}), 32'({1'b1, tx_cap}));
      tx_busy_r = 1'b1;
      obs_tx.push_back(tx_cap);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 tx_busy_r = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    tick();
    rx_d_vld  = 1'b0;
  endtask

  // Sends frame_q with random gaps, then 'junk' back-to-back bytes that land
  // while the DUT is busy and must be discarded.
  task automatic send_frame(input int junk);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, 3)) tick();
      send_byte(frame_q[i]);
    end
    for (int j = 0; j < junk; j++) begin
      case ($urandom_range(0, 4))
        0: send_byte(8'hAA);
        1: send_byte(8'hBB);
        2: send_byte(8'hCC);
        3: send_byte(8'hDD);
        default: send_byte(8'($urandom));
      endcase
    end
    frame_q.delete();
  endtask

  task automatic end_frame(input int ntx);
    int cyc = 0;
    while ((obs_tx.size() < ntx || tx_busy) && cyc < 400) begin
      tick();
      cyc++;
    end
    if (cyc >= 400) chk("frame_timeout_tx_count", 32'(obs_tx.size()), 32'(ntx));
    repeat (4) tick();
    chk("n_wr", 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) chk("wr", 32'(obs_wr[i]), 32'(exp_wr[i]));
    chk("n_rd", 32'(obs_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) chk("rd", 32'(obs_rd[i]), 32'(exp_rd[i]));
    chk("n_alu", 32'(obs_alu.size()), 32'(exp_alu.size()));
    for (int i = 0; i < obs_alu.size() && i < exp_alu.size(); i++) chk("alu_fun", 32'(obs_alu[i]), 32'(exp_alu[i]));
    chk("n_tx", 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) chk("tx", 32'(obs_tx[i]), 32'(exp_tx[i]));
    chk("gate_idle", 32'(clk_gate_en), 32'(0));
    obs_wr.delete(); exp_wr.delete();
    obs_rd.delete(); exp_rd.delete();
    obs_alu.delete(); exp_alu.delete();
    obs_tx.delete(); exp_tx.delete();
  endtask

  // Reference model: expected effects of each frame type
  task automatic exp_alu_run(input logic [7:0] f);
    logic [15:0] r;
    r = alu_force_en ? alu_force_val : alu_ref(f[3:0], mem_m[0], mem_m[1]);
    exp_alu.push_back(f[3:0]);
    exp_tx.push_back(r[7:0]);
    exp_tx.push_back(r[15:8]);
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d);
    frame_q = {8'hAA, a, d};
    exp_wr.push_back({a[3:0], d});
    mem_m[a[3:0]] = d;
    send_frame(0);
    end_frame(0);
  endtask

  task automatic do_rd(input logic [7:0] a, input int junk);
    frame_q = {8'hBB, a};
    exp_rd.push_back(a[3:0]);
    exp_tx.push_back(mem_m[a[3:0]]);
    send_frame(junk);
    end_frame(1);
  endtask

  task automatic do_alu_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input int junk);
    frame_q = {8'hCC, a, b, f};
    exp_wr.push_back({4'd0, a});
    exp_wr.push_back({4'd1, b});
    mem_m[0] = a;
    mem_m[1] = b;
    exp_alu_run(f);
    send_frame(junk);
    end_frame(2);
  endtask

  task automatic do_alu_no(input logic [7:0] f, input int junk);
    frame_q = {8'hDD, f};
    exp_alu_run(f);
    send_frame(junk);
    end_frame(2);
  endtask

  task automatic do_junk(input logic [7:0] b);
    frame_q = {b};
    send_frame(0);
    end_frame(0);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, 32'({rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
                  clk_gate_en, tx_p_data, tx_d_vld}), 32'(0));
  endtask

  initial begin
    int cyc;
    int cnt;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = '0;
      mem_m[i]  = '0;
    end

    repeat (3) tick();
    chk_outs_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) tick();

    // Plain write; then a read of address 7 with data returned 3 cycles later
    do_wr(8'h05, 8'h3C);
    do_wr(8'h07, 8'h5A);
    rd_dly = 3;
    do_rd(8'h07, 0);

    // Full ALU frame with a fixed ALU result 4 cycles after start
    alu_dly = 4;
    alu_force_en = 1'b1;
    alu_force_val = 16'h0468;
    do_alu_op(8'h12, 8'h34, 8'h02, 0);
    alu_force_en = 1'b0;

    // Transmitter busy for 20 cycles when the first result byte is ready
    busy_force = 1'b1;
    frame_q = {8'hDD, 8'h00};
    exp_alu_run(8'h00);
    send_frame(0);
    cyc = 0;
    while (!alu_out_vld && cyc < 100) begin
      tick();
      cyc++;
    end
    if (cyc >= 100) chk("alu_vld_wait_timeout", 32'(cyc), 32'(0));
    cnt = 0;
    repeat (20) begin
      tick();
      if (tx_d_vld) cnt++;
    end
    chk("tx_vld_while_busy", 32'(cnt), 32'(0));
    busy_force = 1'b0;
    end_frame(2);

    // Non-command byte ignored, then ALU-no-operand frame with junk during the wait
    do_junk(8'h55);
    do_alu_no(8'h01, 2);

    // Reset mid-frame after CC,12: outputs drop at once, frame abandoned
    frame_q = {8'hCC, 8'h12};
    exp_wr.push_back({4'd0, 8'h12});
    mem_m[0] = 8'h12;
    send_frame(0);
    repeat (2) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    rst_cnt++;
    #1 chk_outs_zero("reset_async_midframe");
    tick();
    rst_n = 1'b1;
    frame_q = {8'h34, 8'h02};
    send_frame(0);
    end_frame(0);
    do_wr(8'h01, 8'hFF);

    // Reset while the ALU clock gate is open
    alu_dly = 30;
    frame_q = {8'hDD, 8'h03};
    exp_alu.push_back(4'h3);
    send_frame(0);
    repeat (5) tick();
    chk("gate_on_in_alu_wait", 32'(clk_gate_en), 32'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    rst_cnt++;
    #1 chk("reset_async_gate", 32'({clk_gate_en, alu_en, alu_fun}), 32'(0));
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    end_frame(0);

    // Random frames
    for (int n = 0; n < 150; n++) begin
      rd_dly  = $urandom_range(1, 5);
      alu_dly = $urandom_range(1, 6);
      case ($urandom_range(0, 4))
        0: do_wr(8'($urandom), 8'($urandom));
        1: do_rd(8'($urandom), $urandom_range(0, 2));
        2: do_alu_op(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        3: do_alu_no(8'($urandom), $urandom_range(0, 2));
        default: begin
          b = 8'($urandom);
          if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'h55;
          do_junk(b);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
